alu_seq: RTL
============

# alu_seq

Parametrised sequential ALU, the next generation of the board-level 3-bit ALU. It takes two W-bit unsigned operands and one opcode, and runs one operation per start pulse: add, subtract, shift-add multiply, or restoring divide. It reports completion with a one-cycle done pulse and holds a 2W-bit result stable for the display path (binary-to-BCD / seven-segment driver) until the next completion.

## Interface
- W, default 4: operand width in bits; legal range 2..8.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle.
- opcode  in  2  operation select: 00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled with start.
- port_a  in  W  operand A (unsigned), sampled with start.
- port_b  in  W  operand B (unsigned), sampled with start.
- busy  out  1  high while an iterative operation is running.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  out  2W  operation result (see Operation).
- neg  out  1  SUB only: B > A; result holds the magnitude |A−B|.
- dz  out  1  DIV only: divide by zero.

## Operation
- FSM states: IDLE, ITER.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the iteration counter clears.
  - result, neg, dz, done and busy all go to 0.
  - An operation in progress is abandoned; no done is issued for it.
- IDLE, start=1: operands and opcode are captured.
  - ADD: result = zero-extended {1'b0,A}+{1'b0,B} (W+1 significant bits). neg=0, dz=0. done is asserted and the FSM stays in IDLE.
  - SUB: if A≥B, result = A−B and neg=0; otherwise result = B−A and neg=1. Zero-extended. dz=0. done is asserted and the FSM stays in IDLE.
  - DIV with B=0: result = {A, all-ones quotient}, i.e. result[2W-1:W]=A and result[W-1:0]=2^W−1. dz=1, neg=0. done is asserted and the FSM stays in IDLE.
  - MUL, or DIV with B≠0: the FSM moves to ITER and the counter loads W.
- ITER performs one step per cycle, LSB-first shift-add for MUL and MSB-first restoring for DIV, and decrements the counter.
  - On the step where the counter is 1, result is written and done is asserted. neg and dz are cleared, and the FSM returns to IDLE.
  - MUL: result = A×B, full 2W bits.
  - DIV: result[W-1:0] = quotient, result[2W-1:W] = remainder.
- start is ignored while in ITER. Operands and opcode may change freely during ITER without effect.
- result, neg and dz change only in a done cycle or on reset. Between completions they hold their values.
- busy = (state == ITER).

## Timing
- Start sampled at rising edge k:
  - ADD, SUB and DIV-by-zero: done and result are valid in cycle k+1 (latency 1).
  - MUL and DIV: busy is high in cycles k+1..k+W. done and result are valid in cycle k+W+1 (latency W+1), and busy is low in that cycle.
- done is a registered pulse, exactly one cycle wide. It never coincides with busy.
- Back-to-back operation: the FSM is in IDLE during the done cycle, so a start in that cycle is accepted. Throughput is 1 op/cycle for ADD and SUB, and 1 op per W+1 cycles for MUL and DIV.
- Reset has priority over everything. When rst is released mid-cycle, the first start is accepted at the next rising edge.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - FSM state encodings S_IDLE, S_ITER.
- The display path imports the same opcode constants.
- One sub-module, alu_seq_step. It is combinational and holds the single shift-add / restoring-divide step: inputs are accumulator, operand and mode; outputs are the next accumulator and operand. This keeps the FSM/counter separate from the arithmetic.
- Internal registers:
  - 2W-bit accumulator;
  - W-bit operand copy;
  - opcode copy;
  - counter of width clog2(W+1).

## Test plan (W=4)
- ADD 7+9, then immediately ADD 15+15 in the done cycle -> result=0x10 with done in cycle k+1; result=0x1E one cycle later; neg=0, busy never high.
- SUB 3−9, then SUB 9−3 -> result=6 with neg=1, then result=6 with neg=0, each with latency 1.
- MUL 15×15 -> busy high for 4 cycles, done in cycle k+5 with result=0xE1; a start pulse (ADD 1+1) during busy is ignored, with no extra done.
- DIV 13/4 -> done at k+5 with result[3:0]=3, result[7:4]=1, dz=0; then DIV 9/0 -> done at k+1 with result=0x9F, dz=1.
- Reset low in the 2nd busy cycle of MUL 6×7 -> busy, done and result go to 0 immediately, no done follows; after release, MUL 6×7 -> result=0x2A at k+5.
- DIV 0/7 and MUL 0×15 -> result=0, dz=0, latency 5; result holds steady across 10 idle cycles afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU and its display path.
// Holds the opcode encodings, FSM states and the step-mode select.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ITER = 1'b1
   } state_t;

   typedef enum logic {
      M_MUL = 1'b0,
      M_DIV = 1'b1
   } step_mode_t;

endpackage

// File: rtl/alu_seq_step.sv
// One iteration of LSB-first shift-add multiply or
// MSB-first restoring divide on a {high, low} accumulator.
import alu_pkg::*;

module alu_seq_step #(
   parameter int W = 4
) (
   input  logic [2*W-1:0] acc,
   input  logic [W-1:0]   opnd,
   input  step_mode_t     mode,
   output logic [2*W-1:0] acc_nxt,
   output logic [W-1:0]   opnd_nxt
);

   logic [W:0] sum;
   logic [W:0] rem_sh;
   logic [W:0] diff;

   // diff[W] is the borrow: set exactly when the shifted remainder < divisor
   always_comb begin
      sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      rem_sh   = acc[2*W-1:W-1];
      diff     = rem_sh - {1'b0, opnd};
      opnd_nxt = opnd;
      if (mode == M_MUL)
         acc_nxt = {sum, acc[W-1:1]};
      else if (diff[W])
         acc_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      else
         acc_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub, W-step multiply/divide,
// registered one-cycle done pulse and held result.
import alu_pkg::*;

module alu_seq #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     opcode,
   input  logic [W-1:0]   port_a,
   input  logic [W-1:0]   port_b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           neg,
   output logic           dz
);

   localparam int CW = $clog2(W + 1);

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [2*W-1:0] acc, acc_n, acc_step;
   logic [W-1:0]   opnd, opnd_n, opnd_step;
   logic [1:0]     op, op_n;
   logic [2*W-1:0] result_n;
   logic           neg_n, dz_n, done_n;
   logic [W:0]     sum_ab;
   step_mode_t     mode;

   assign mode = (op == OP_DIV) ? M_DIV : M_MUL;
   assign busy = (state == S_ITER);
   assign sum_ab = {1'b0, port_a} + {1'b0, port_b};

   alu_seq_step #(.W(W)) u_step (
      .acc      (acc),
      .opnd     (opnd),
      .mode     (mode),
      .acc_nxt  (acc_step),
      .opnd_nxt (opnd_step)
   );

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      acc_n    = acc;
      opnd_n   = opnd;
      op_n     = op;
      result_n = result;
      neg_n    = neg;
      dz_n     = dz;
      done_n   = 1'b0;
      unique case (state)
         S_IDLE: if (start) begin
            op_n   = opcode;
            opnd_n = port_b;
            acc_n  = {{W{1'b0}}, port_a};
            unique case (1'b1)
               (opcode == OP_ADD): begin
                  result_n = {{(W-1){1'b0}}, sum_ab};
                  neg_n    = 1'b0;
                  dz_n     = 1'b0;
                  done_n   = 1'b1;
               end
               (opcode == OP_SUB): begin
                  neg_n    = (port_b > port_a);
                  result_n = {{W{1'b0}},
                     neg_n ? port_b - port_a : port_a - port_b};
                  dz_n     = 1'b0;
                  done_n   = 1'b1;
               end
               (opcode == OP_DIV && port_b == '0): begin
                  result_n = {port_a, {W{1'b1}}};
                  neg_n    = 1'b0;
                  dz_n     = 1'b1;
                  done_n   = 1'b1;
               end
               default: begin
                  state_n = S_ITER;
                  cnt_n   = CW'(W);
               end
            endcase
         end
         S_ITER: begin
            acc_n  = acc_step;
            opnd_n = opnd_step;
            cnt_n  = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               result_n = acc_step;
               neg_n    = 1'b0;
               dz_n     = 1'b0;
               done_n   = 1'b1;
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         op     <= OP_ADD;
         result <= '0;
         neg    <= 1'b0;
         dz     <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         acc    <= acc_n;
         opnd   <= opnd_n;
         op     <= op_n;
         result <= result_n;
         neg    <= neg_n;
         dz     <= dz_n;
         done   <= done_n;
      end
   end

endmodule
